// File: rtl/pmod_pos_tx.sv
// rtl/pmod_pos_tx.sv - debounced, clamped player-position transmitter onto PMOD JA/JB/JC
module pmod_pos_tx #(
    parameter int STABLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int X_MAX         = 1023,
    parameter int Y_MAX         = 767
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    output logic [7:0]  JA,
    output logic [7:0]  JB,
    output logic [7:0]  JC,
    output logic        update,
    output logic        busy
);

    localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [11:0]   XM          = 12'(X_MAX);
    localparam logic [11:0]   YM          = 12'(Y_MAX);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   s_x_q, s_y_q;
    logic [11:0]   cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [11:0]   drv_x_q, drv_x_d, drv_y_q, drv_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          update_q, update_d;

    logic s_ne_drv, s_ne_cand;

    // Input stage is a plain pipeline register; it needs no reset because the
    // FSM only ever looks at it after reset has set a known driven word.
    always_ff @(posedge clk) begin
        s_x_q <= (xpos_in > XM) ? XM : xpos_in;
        s_y_q <= (ypos_in > YM) ? YM : ypos_in;
    end

    assign s_ne_drv  = {s_x_q, s_y_q} != {drv_x_q, drv_y_q};
    assign s_ne_cand = {s_x_q, s_y_q} != {cand_x_q, cand_y_q};

    always_comb begin
        state_d  = state_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        drv_x_d  = drv_x_q;
        drv_y_d  = drv_y_q;
        cnt_d    = cnt_q;
        update_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && s_ne_drv) begin
                    state_d  = WAIT;
                    cand_x_d = s_x_q;
                    cand_y_d = s_y_q;
                    cnt_d    = '0;
                end
            end
            WAIT: begin
                if (!en || !s_ne_drv) begin
                    state_d = IDLE;
                end else if (s_ne_cand) begin
                    cand_x_d = s_x_q;
                    cand_y_d = s_y_q;
                    cnt_d    = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    drv_x_d  = cand_x_q;
                    drv_y_d  = cand_y_q;
                    update_d = 1'b1;
                    state_d  = HOLD;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_x_q <= '0;
            cand_y_q <= '0;
            drv_x_q  <= '0;
            drv_y_q  <= '0;
            cnt_q    <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            drv_x_q  <= drv_x_d;
            drv_y_q  <= drv_y_d;
            cnt_q    <= cnt_d;
            update_q <= update_d;
        end
    end

    // The driven word is the pin register: all 24 bits change on one edge.
    assign JB     = drv_x_q[7:0];
    assign JC     = {drv_y_q[3:0], drv_x_q[11:8]};
    assign JA     = drv_y_q[11:4];
    assign update = update_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: doc/pmod_pos_tx.md
Name: pmod_pos_tx

Overview:
- Transmit side of the board-to-board player-position link. Takes the local player's mouse position and drives it onto the three 8-bit PMOD ports JA/JB/JC in the link's pin packing.
- The far board samples the pins every clock with no strobe. The pins must therefore change only as one coherent word, and only after the input has settled. This prevents torn or glitching coordinates at the receiver.
- Sits between the mouse-position path and the top-level PMOD outputs.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles a new position must be unchanged before it is committed to the pins (min 1).
- HOLD_CYCLES, 16, minimum cycles the pins stay frozen after a commit (min 1).
- X_MAX, 1023, maximum transmitted x; larger values clamp to X_MAX.
- Y_MAX, 767, maximum transmitted y; larger values clamp to Y_MAX.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  transmit enable; when low, pins are frozen
- xpos_in  in  12  local player x position
- ypos_in  in  12  local player y position
- JA  out  8  PMOD port A: y[11:4]
- JB  out  8  PMOD port B: x[7:0]
- JC  out  8  PMOD port C: [7:4]=y[3:0], [3:0]=x[11:8]
- update  out  1  one-cycle pulse, high in the cycle the pins take a new value
- busy  out  1  high while state is WAIT or HOLD

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset values: JA=JB=JC=0, update=0, busy=0; driven word d=(0,0); state IDLE; counter 0.
- Input stage: every edge, s <= (clamp(xpos_in,X_MAX), clamp(ypos_in,Y_MAX)).
  - clamp(v,M) = (v>M) ? M : v, unsigned compare.
- Pins are registered directly from d: JB=d.x[7:0], JC={d.y[3:0], d.x[11:8]}, JA=d.y[11:4]. No combinational path from the inputs to the pins.
- FSM state IDLE:
  - If en=1 and s!=d: go to WAIT, cand<=s, cnt<=0.
  - Otherwise stay in IDLE.
- FSM state WAIT:
  - If en=0: go to IDLE, no commit.
  - Else if s==d (input reverted to the driven value): go to IDLE.
  - Else if s!=cand: cand<=s, cnt<=0 (restart count).
  - Else if cnt==STABLE_CYCLES-1: commit, i.e. d<=cand and update<=1 for one cycle; go to HOLD with cnt<=0.
  - Else cnt<=cnt+1.
- FSM state HOLD:
  - Pins frozen; inputs ignored.
  - cnt<=cnt+1; when cnt==HOLD_CYCLES-1, go to IDLE.
- Latency: take edge 0 as the edge where a new stable input is sampled into s. Pins show the new word after edge STABLE_CYCLES+1, e.g. edge 5 with defaults. update is high in the cycle following that edge.
- Throughput: at most one commit per STABLE_CYCLES+HOLD_CYCLES+1 cycles.
- en=0 in HOLD does not cut HOLD short. HOLD completes, then the FSM stays in IDLE.
- Reset asserted in any state: the next edge forces all reset values, and the pins go to 0 immediately. A pending cand is discarded.
- cnt width: clog2(max(STABLE_CYCLES,HOLD_CYCLES))+1 bits. cnt never wraps.
- All 24 pin bits update on the same edge. A partial update is never allowed.

Test Plan:
- Reset then idle: assert rst 2 cycles -> JA=JB=JC=0x00, update=0, busy=0; hold inputs at 0 for 20 cycles -> no update pulse.
- Single move: en=1, x=0x2A5, y=0x1C3 held -> after edge 5 from sampling, JB=0xA5, JC=0x32, JA=0x1C; exactly one update pulse; busy high through 16 HOLD cycles, then low.
- Jitter rejection: x alternates 100/101 every 2 cycles with y=50 -> no commit while alternating; x then settles at 101 -> commit 5 edges later, JB=0x65, JA=0x03, JC=0x20.
- Revert: pins at (10,10); input goes to (11,10) for 2 cycles, then back to (10,10) -> FSM returns to IDLE, no update pulse, pins unchanged.
- Clamp and hold-off: input x=0xFFF, y=0x900 -> pins carry x=1023, y=767 (JB=0xFF, JC=0xF3, JA=0x2F). A new input during HOLD is not committed before HOLD ends; it is then committed STABLE_CYCLES+1 cycles after HOLD exits.
- Enable/reset mid-operation: drop en in WAIT at cnt=2 -> no commit. Assert rst during HOLD -> pins read 0 after the next edge; after release the FSM restarts from IDLE.
